// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the modular-exponentiation datapath.
package rsa_pkg;

    localparam int N_WIDTH_DEF = 1024;
    localparam int E_WIDTH_DEF = 32;
    localparam int IDX_W       = $clog2(E_WIDTH_DEF) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SQR,
        ST_MUL,
        ST_POST,
        ST_DONE
    } mont_exp_state_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer around an external Montgomery
// multiplier. PRE maps x into the Montgomery domain and seeds acc with R mod M,
// SQR/MUL walk the exponent from its top processed bit down, and POST
// multiplies by 1 to leave the Montgomery domain.
module mont_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int E_WIDTH = E_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [E_WIDTH-1:0]           exp_in,
    input  logic [$clog2(E_WIDTH):0]     exp_len,
    input  logic [N_WIDTH-1:0]           x_in,
    input  logic [N_WIDTH-1:0]           r_mod_m,
    input  logic [N_WIDTH-1:0]           r2_mod_m,
    output logic                         mm_start,
    output logic [N_WIDTH-1:0]           mm_a,
    output logic [N_WIDTH-1:0]           mm_b,
    input  logic                         mm_done,
    input  logic [N_WIDTH-1:0]           mm_result,
    output logic [N_WIDTH-1:0]           result
);

    localparam int LW    = $clog2(E_WIDTH) + 1;
    localparam int BIT_W = $clog2(E_WIDTH);

    mont_exp_state_t     state_q, state_d;
    logic [N_WIDTH-1:0]  acc_q, acc_d;
    logic [N_WIDTH-1:0]  xt_q, xt_d;
    logic [E_WIDTH-1:0]  e_reg_q, e_reg_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic                pending_q, pending_d;
    logic                mm_start_q, mm_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_WIDTH-1:0]  result_q, result_d;

    logic [LW-1:0]       idx_m1;
    logic                take;
    logic                launch;

    // Next-state, datapath register updates and registered output values.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        xt_d       = xt_q;
        e_reg_d    = e_reg_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        mm_start_d = 1'b0;
        launch     = 1'b0;
        idx_m1     = idx_q - LW'(1);
        // A completion only counts when a multiplication is outstanding.
        take       = pending_q && mm_done;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xt_d    = x_in;
                    e_reg_d = exp_in;
                    idx_d   = (exp_len > LW'(E_WIDTH)) ? LW'(E_WIDTH) : exp_len;
                    state_d = ST_PRE;
                    launch  = 1'b1;
                end
            end
            ST_PRE: begin
                if (take) begin
                    xt_d    = mm_result;
                    acc_d   = r_mod_m;
                    state_d = (idx_q != '0) ? ST_SQR : ST_POST;
                    launch  = 1'b1;
                end
            end
            ST_SQR: begin
                if (take) begin
                    acc_d  = mm_result;
                    idx_d  = idx_m1;
                    launch = 1'b1;
                    if (e_reg_q[idx_m1[BIT_W-1:0]]) begin
                        state_d = ST_MUL;
                    end else if (idx_m1 != '0) begin
                        state_d = ST_SQR;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_MUL: begin
                if (take) begin
                    acc_d   = mm_result;
                    state_d = (idx_q != '0) ? ST_SQR : ST_POST;
                    launch  = 1'b1;
                end
            end
            ST_POST: begin
                if (take) begin
                    acc_d   = mm_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Require start to drop so a held level cannot retrigger.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            pending_d = 1'b0;
        end
        if (launch) begin
            pending_d  = 1'b1;
            mm_start_d = 1'b1;
        end

        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d   = (state_d == ST_DONE);
        result_d = (state_d == ST_DONE) ? acc_d : '0;
    end

    // Operand mux; acc and xt only change on a completion, so the operands
    // hold steady for the whole multiplication.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            ST_PRE: begin
                mm_a = xt_q;
                mm_b = r2_mod_m;
            end
            ST_SQR: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            ST_MUL: begin
                mm_a = acc_q;
                mm_b = xt_q;
            end
            ST_POST: begin
                mm_a = acc_q;
                mm_b = N_WIDTH'(1);
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    // State and output registers; async reset abandons any run in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            xt_q       <= '0;
            e_reg_q    <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            xt_q       <= xt_d;
            e_reg_q    <= e_reg_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign mm_start = mm_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule
